seg7_bin2dig_encoder: RTL and testbench

Upstream feeder for the two-digit seven-segment multiplexer. Accepts a binary value on a load strobe and converts it to two BCD digits with an iterative shift-and-add-3 (double-dabble) engine. It encodes each digit to a 7-bit segment pattern and presents both patterns as one registered 14-bit bus, both7seg, which the multiplexer alternates onto the display. Output changes atomically, and only on conversion completion.

---
 rtl/seven_seg_pkg.sv | 27 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/seg7_bin2dig_encoder.sv | 121 ++++++++++++
 tb/tb_seg7_bin2dig_encoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the binary-to-seven-segment feeder.
// Segment patterns are active high, bit 6 = a down to bit 0 = g.
package seven_seg_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ENCODE
  } conv_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment pattern; non-decimal codes show a dash.
module bcd_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_bin2dig_encoder.sv
// Loads a binary value, converts it to two BCD digits by double-dabble and
// presents both segment patterns as one registered bus, updated atomically.
module seg7_bin2dig_encoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned VAL_W       = 7,
  parameter bit          BLANK_LZ    = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VAL_W-1:0]     value,
  input  logic                 load,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [2*SEG_W-1:0]   both7seg
);

  localparam int unsigned CNT_W = $clog2(VAL_W + 1);
  localparam int unsigned VEC_W = 2 * DIGIT_W + VAL_W;
  localparam logic [2*SEG_W-1:0] SEG_POL = {(2 * SEG_W){SEG_ACT_LOW}};

  conv_state_t           state_q, state_d;
  logic [VAL_W-1:0]      shreg_q;
  logic [DIGIT_W-1:0]    tens_q, units_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ovf_pend_q;
  logic                  done_q;
  logic                  ovf_q;
  logic [2*SEG_W-1:0]    seg_q;

  logic                  ovf_in;
  logic [DIGIT_W-1:0]    tens_adj, units_adj;
  logic [VEC_W-1:0]      shift_vec;
  logic [SEG_W-1:0]      seg_tens, seg_units, seg_upper;
  logic [2*SEG_W-1:0]    seg_next;

  assign ovf_in = (32'(value) > 32'd99);

  // Add-3 correction precedes the shift; the hundreds carry falls off the top.
  assign tens_adj  = (tens_q  >= 4'd5) ? tens_q  + 4'd3 : tens_q;
  assign units_adj = (units_q >= 4'd5) ? units_q + 4'd3 : units_q;
  assign shift_vec = {tens_adj, units_adj, shreg_q} << 1;

  bcd_to_seg7 u_tens_enc (
    .digit (tens_q),
    .seg   (seg_tens)
  );

  bcd_to_seg7 u_units_enc (
    .digit (units_q),
    .seg   (seg_units)
  );

  always_comb begin
    seg_upper = seg_tens;
    if (BLANK_LZ && (tens_q == '0)) begin
      seg_upper = SEG_BLANK;
    end
    seg_next = {seg_upper, seg_units};
    if (ovf_pend_q) begin
      seg_next = {SEG_DASH, SEG_DASH};
    end
    seg_next = seg_next ^ SEG_POL;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = ENCODE;
      ENCODE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      tens_q     <= '0;
      units_q    <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      seg_q      <= SEG_POL;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            shreg_q    <= value;
            tens_q     <= '0;
            units_q    <= '0;
            cnt_q      <= CNT_W'(VAL_W);
            ovf_pend_q <= ovf_in;
          end
        end
        SHIFT: begin
          {tens_q, units_q, shreg_q} <= shift_vec;
          cnt_q                      <= cnt_q - 1'b1;
        end
        ENCODE: begin
          seg_q  <= seg_next;
          ovf_q  <= ovf_pend_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign both7seg = seg_q;

endmodule

// File: tb/tb_seg7_bin2dig_encoder.sv
// Scoreboard bench: three encoder variants (blanking on/off, inverted output) in lockstep.
module tb_seg7_bin2dig_encoder;

  localparam int unsigned VAL_W = 7;
  localparam int unsigned NV    = 3;
  localparam bit BLZ  [NV] = '{1'b1, 1'b0, 1'b1};
  localparam bit ACTL [NV] = '{1'b0, 1'b0, 1'b1};
  localparam logic [6:0] SEG_TBL [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  typedef struct packed {
    logic [NV-1:0][13:0] seg;
    logic                ovf;
    logic [31:0]         cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic [VAL_W-1:0] value = '0;
  logic [13:0]      seg_o  [NV];
  logic             busy_o [NV];
  logic             done_o [NV];
  logic             ovf_o  [NV];

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          errs = 0;
  int          checks = 0;
  logic [31:0] cyc = 0;
  logic [13:0] last_seg [NV];
  logic        rst_prev = 1'b1;

  seg7_bin2dig_encoder #(.VAL_W(VAL_W), .BLANK_LZ(1'b1), .SEG_ACT_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .value(value), .load(load), .busy(busy_o[0]),
    .done(done_o[0]), .overflow(ovf_o[0]), .both7seg(seg_o[0])
  );
  seg7_bin2dig_encoder #(.VAL_W(VAL_W), .BLANK_LZ(1'b0), .SEG_ACT_LOW(1'b0)) dut1 (
    .clk(clk), .rst(rst), .value(value), .load(load), .busy(busy_o[1]),
    .done(done_o[1]), .overflow(ovf_o[1]), .both7seg(seg_o[1])
  );
  seg7_bin2dig_encoder #(.VAL_W(VAL_W), .BLANK_LZ(1'b1), .SEG_ACT_LOW(1'b1)) dut2 (
    .clk(clk), .rst(rst), .value(value), .load(load), .busy(busy_o[2]),
    .done(done_o[2]), .overflow(ovf_o[2]), .both7seg(seg_o[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected display straight from the decimal digits of v.
  function automatic logic [13:0] model(input int v, input bit blz, input bit al);
    logic [13:0] r;
    int          tens;
    if (v > 99) begin
      r = {7'b0000001, 7'b0000001};
    end else begin
      tens = v / 10;
      r = {(blz && tens == 0) ? 7'b0000000 : SEG_TBL[tens], SEG_TBL[v % 10]};
    end
    return al ? ~r : r;
  endfunction

  task automatic push(input int v);
    exp_t e;
    for (int i = 0; i < NV; i++) e.seg[i] = model(v, BLZ[i], ACTL[i]);
    e.ovf = (v > 99);
    e.cyc = cyc + VAL_W + 2;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; leaves load low at the following negedge.
  task automatic issue(input int v);
    value = v[VAL_W-1:0];
    load  = 1'b1;
    push(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reset_check(input string tag);
    for (int i = 0; i < NV; i++) begin
      chk({tag, " seg"}, {18'h0, seg_o[i]}, ACTL[i] ? 32'h3fff : 32'h0);
      chk({tag, " busy"}, {31'h0, busy_o[i]}, 0);
      chk({tag, " done"}, {31'h0, done_o[i]}, 0);
      chk({tag, " ovf"}, {31'h0, ovf_o[i]}, 0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (done_o[0] || done_o[1] || done_o[2]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected done", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("latency", cyc, mon_e.cyc);
          for (int i = 0; i < NV; i++) begin
            chk("done", {31'h0, done_o[i]}, 1);
            chk("both7seg", {18'h0, seg_o[i]}, {18'h0, mon_e.seg[i]});
            chk("overflow", {31'h0, ovf_o[i]}, {31'h0, mon_e.ovf});
            chk("busy at done", {31'h0, busy_o[i]}, 0);
          end
        end
      end else if (!rst_prev) begin
        for (int i = 0; i < NV; i++) chk("hold", {18'h0, seg_o[i]}, {18'h0, last_seg[i]});
      end
    end
    for (int i = 0; i < NV; i++) last_seg[i] = seg_o[i];
    rst_prev = rst;
  end

  initial begin
    int v;
    #2 rst = 1'b1;
    #1 reset_check("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(42);
    for (int k = 0; k < 8; k++) begin
      chk("busy during conv", {31'h0, busy_o[0]}, 1);
      @(negedge clk);
    end
    chk("busy after conv", {31'h0, busy_o[0]}, 0);
    drain();

    issue(7);   drain();
    issue(0);   drain();
    issue(100); drain();
    issue(127); drain();
    issue(99);  drain();

    // load held through the conversion; value changes mid-way, re-accepted on done
    value = 7'd33;
    load  = 1'b1;
    push(33);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) value = 7'd55;
      if (done_o[0]) begin
        push(55);
        break;
      end
    end
    @(negedge clk);
    load = 1'b0;
    drain();

    // abort during the shift phase
    issue(88);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1 reset_check("mid reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(88);
    drain();

    repeat (30) begin
      v = int'($urandom_range(0, 127));
      issue(v);
      drain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("queue empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
